// File: rtl/rv32_pkg.sv
// Shared RV32 constants and helpers used by the fetch, decode and pipeline top-level modules.
package rv32_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// In-order prefetch buffer: DEPTH x ILEN words with push, pop and flush; flush beats push.
module fetch_fifo
  import rv32_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [ILEN-1:0]  wdata,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic [ILEN-1:0]  head
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [ILEN-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage carries no reset; validity is tracked entirely by count.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  assign empty = (count == '0);
  assign head  = mem[rd_ptr];
endmodule

// File: rtl/fetch_prefetch.sv
// Instruction fetch stage: sequential imem requests, in-order prefetch queue, stall and redirect.
module fetch_prefetch
  import rv32_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 4,
  parameter int              CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            pc_sel,
  input  logic [XLEN-1:0] pc_nxt,
  output logic            imem_req,
  input  logic            imem_gnt,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [ILEN-1:0] imem_rdata,
  output logic            instr_valid,
  output logic [XLEN-1:0] pc_out,
  output logic [ILEN-1:0] instruction
);
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

  logic [XLEN-1:0]  fetch_pc;
  logic [XLEN-1:0]  head_pc;
  logic [CNT_W-1:0] inflight;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   occupancy;
  logic [ILEN-1:0]  head_word;
  logic             empty;
  logic             fire;
  logic             push;
  logic             pop;

  // Queued plus outstanding words bound issue, so a push always finds a free slot.
  assign occupancy   = {1'b0, count} + {1'b0, inflight};
  assign imem_req    = !rst && !pc_sel && (occupancy < DEPTH_C);
  assign imem_addr   = fetch_pc;
  assign fire        = imem_req && imem_gnt;
  assign push        = imem_rvalid && (drop_cnt == '0) && !pc_sel;
  assign pop         = !empty && !stall && !pc_sel;

  assign instr_valid = !empty;
  assign instruction = empty ? NOP_INSTR : head_word;
  assign pc_out      = head_pc;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (pc_sel),
    .wdata (imem_rdata),
    .empty (empty),
    .count (count),
    .head  (head_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      head_pc  <= RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
    end else begin
      inflight <= inflight + CNT_W'(fire) - CNT_W'(imem_rvalid);
      if (pc_sel) begin
        fetch_pc <= align_word(pc_nxt);
        head_pc  <= align_word(pc_nxt);
        // inflight already counts earlier pending discards, so every survivor becomes a discard.
        drop_cnt <= inflight - CNT_W'(imem_rvalid);
      end else begin
        if (fire) fetch_pc <= fetch_pc + 32'd4;
        if (pop)  head_pc  <= head_pc + 32'd4;
        if (imem_rvalid && (drop_cnt != '0)) drop_cnt <= drop_cnt - CNT_W'(1);
      end
    end
  end

  a_rvalid_has_inflight : assert property (@(posedge clk) disable iff (rst)
    imem_rvalid |-> (inflight != '0));
  a_drop_le_inflight : assert property (@(posedge clk) disable iff (rst)
    drop_cnt <= inflight);
endmodule

// File: tb/tb_fetch_prefetch.sv
// Bench for fetch_prefetch: directed scenarios then randomized traffic against a stream-level model.
module tb_fetch_prefetch;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, pc_sel, imem_gnt, imem_rvalid;
  logic [31:0] pc_nxt, imem_rdata;
  logic        imem_req, instr_valid;
  logic [31:0] imem_addr, pc_out, instruction;

  fetch_prefetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .stall(stall), .pc_sel(pc_sel), .pc_nxt(pc_nxt),
    .imem_req(imem_req), .imem_gnt(imem_gnt), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .pc_out(pc_out), .instruction(instruction)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int gnt_pct = 100;
  int lat_lo = 1;
  int lat_hi = 1;
  int last_rdy = 0;

  // Memory: responses in grant order, tagged with the redirect epoch that issued them.
  logic [31:0] mq_addr[$];
  int          mq_rdy[$];
  int          mq_ep[$];
  int          epoch = 0;

  // Stream model since the last reset/redirect.
  logic [31:0] exp_pc, exp_fetch;
  int          grants, recv, pops;

  logic        o_valid, o_req;
  logic [31:0] o_pc, o_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_restart(input logic [31:0] target);
    epoch++;
    grants = 0; recv = 0; pops = 0;
    exp_pc = {target[31:2], 2'b00};
    exp_fetch = exp_pc;
  endtask

  function automatic int stale_count();
    int n = 0;
    foreach (mq_ep[i]) if (mq_ep[i] != epoch) n++;
    return n;
  endfunction

  task automatic step(input logic s, input logic ps, input logic [31:0] nx);
    int lat, rdy;
    stall = s; pc_sel = ps; pc_nxt = nx;
    imem_gnt = ($urandom_range(99) < gnt_pct);
    if (mq_addr.size() > 0 && mq_rdy[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(mq_addr[0]);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    #1;
    o_valid = instr_valid; o_req = imem_req; o_pc = pc_out; o_addr = imem_addr;
    check("pc_out", pc_out, exp_pc);
    check("instr_valid", {31'b0, instr_valid}, {31'b0, (recv - pops) > 0});
    if (instr_valid) check("instruction", instruction, mem_word(exp_pc));
    else             check("nop", instruction, NOP);
    check("imem_req", {31'b0, imem_req},
          {31'b0, !ps && ((grants - pops) + stale_count()) < DEPTH});
    if (imem_req) check("imem_addr", imem_addr, exp_fetch);
    if (recv < pops) check("underflow", 32'(recv), 32'(pops));
    // Apply the effects of the coming clock edge to the model.
    if (imem_rvalid) begin
      if (mq_ep[0] == epoch && !ps) recv++;
      void'(mq_addr.pop_front()); void'(mq_rdy.pop_front()); void'(mq_ep.pop_front());
    end
    if (imem_req && imem_gnt) begin
      lat = $urandom_range(lat_hi, lat_lo);
      rdy = cyc + lat;
      if (rdy <= last_rdy) rdy = last_rdy + 1;
      last_rdy = rdy;
      mq_addr.push_back(imem_addr); mq_rdy.push_back(rdy); mq_ep.push_back(epoch);
      grants++;
      exp_fetch += 32'd4;
    end
    if (instr_valid && !s && !ps) begin
      pops++;
      exp_pc += 32'd4;
    end
    if (ps) model_restart(nx);
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, {31'b0, instr_valid}, 32'd0);
    check({tag, "_req"}, {31'b0, imem_req}, 32'd0);
    check({tag, "_pc"}, pc_out, RESET_PC);
    check({tag, "_addr"}, imem_addr, RESET_PC);
    check({tag, "_instr"}, instruction, NOP);
  endtask

  initial begin
    logic [31:0] frozen_pc;
    rst = 1'b1; stall = 0; pc_sel = 0; pc_nxt = 0;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    model_restart(RESET_PC);

    // 1: 1-cycle memory, free-running stream, two-cycle fill.
    gnt_pct = 100; lat_lo = 1; lat_hi = 1;
    step(0, 0, 0);
    check("fill_c0_valid", {31'b0, o_valid}, 32'd0);
    step(0, 0, 0);
    step(0, 0, 0);
    check("fill_c2_valid", {31'b0, o_valid}, 32'd1);
    check("fill_c2_pc", o_pc, 32'h0);
    check("fill_c2_addr", o_addr, 32'h8);
    repeat (8) step(0, 0, 0);

    // 2: five-cycle stall freezes output and throttles issue.
    frozen_pc = pc_out;
    repeat (5) begin
      step(1, 0, 0);
      check("stall_frozen_pc", o_pc, frozen_pc);
    end
    check("stall_req_low", {31'b0, o_req}, 32'd0);
    repeat (10) step(0, 0, 0);

    // 3: redirect with responses in flight on a 3-cycle memory.
    lat_lo = 3; lat_hi = 3;
    repeat (6) step(0, 0, 0);
    step(0, 1, 32'h100);
    step(0, 0, 0);
    check("redir_next_valid", {31'b0, o_valid}, 32'd0);
    check("redir_pc", o_pc, 32'h100);
    repeat (8) step(0, 0, 0);

    // 4: redirect wins over stall, misaligned target.
    lat_lo = 1; lat_hi = 2;
    step(1, 1, 32'h203);
    step(0, 0, 0);
    check("redir_stall_pc", o_pc, 32'h200);
    repeat (8) step(0, 0, 0);

    // Wrap-around past 2^32.
    step(0, 1, 32'hFFFF_FFF4);
    repeat (12) step(0, 0, 0);

    // 5: asynchronous reset mid-stream.
    lat_lo = 4; lat_hi = 4;
    repeat (4) step(0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    imem_rvalid = 0; imem_gnt = 0;
    mq_addr.delete(); mq_rdy.delete(); mq_ep.delete();
    last_rdy = cyc;
    model_restart(RESET_PC);
    @(posedge clk); cyc++;
    #1;
    rst = 1'b0;
    lat_lo = 1; lat_hi = 1;
    step(0, 0, 0);
    check("post_rst_addr", o_addr, RESET_PC);
    repeat (6) step(0, 0, 0);

    // 6: randomized traffic.
    gnt_pct = 70; lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 10000; i++) begin
      logic s, ps;
      s  = ($urandom_range(99) < 25);
      ps = ($urandom_range(99) < 5);
      step(s, ps, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
